// File: rtl/frame_write_arbiter_pkg.sv
// Shared types and defaults for the camera-to-SRAM write path.
package frame_write_arbiter_pkg;

  // Frame geometry defaults (downsampled camera coordinates).
  localparam int H_MAX_DEFAULT = 640;
  localparam int V_MAX_DEFAULT = 480;
  localparam int DEPTH_DEFAULT = 16;

  // Bus widths.
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;

  // RGB565 field widths used by the colour-conversion and filter stages.
  localparam int RGB565_R_W = 5;
  localparam int RGB565_G_W = 6;
  localparam int RGB565_B_W = 5;

  // One queued SRAM write: address is {y,x}, data is the RGB565 pixel.
  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } pixel_entry_t;

  // Per-cycle decision of the SRAM port arbiter.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_op_t;

  // True when a coordinate lies inside the visible frame.
  function automatic logic in_frame(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input int h_max,
                                    input int v_max);
    return (int'({22'd0, x}) < h_max) && (int'({22'd0, y}) < v_max);
  endfunction

endpackage

// File: rtl/frame_write_arbiter_if.sv
// Pixel input, VGA read and SRAM controller signals of the write arbiter.
// Handshake: pix_valid qualifies pix_x/pix_y/pix_data for exactly one cycle
// and there is no back-pressure (a pixel that cannot be queued is dropped);
// rd_req qualifies rd_addr for one cycle; sram_readdatavalid qualifies
// sram_readdata for one cycle; sram_read/sram_write each mark one command.
interface frame_write_arbiter_if #(
  parameter int DEPTH = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             pix_valid;
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic [15:0]      pix_data;
  logic             freeze;
  logic             rd_req;
  logic [19:0]      rd_addr;
  logic [15:0]      rd_data;
  logic             rd_valid;
  logic [19:0]      sram_address;
  logic             sram_read;
  logic             sram_write;
  logic [15:0]      sram_writedata;
  logic [15:0]      sram_readdata;
  logic             sram_readdatavalid;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0]      drop_count;

  // Arbiter side.
  modport slave (
    input  pix_valid, pix_x, pix_y, pix_data, freeze,
    input  rd_req, rd_addr,
    output rd_data, rd_valid,
    output sram_address, sram_read, sram_write, sram_writedata,
    input  sram_readdata, sram_readdatavalid,
    output fifo_level, drop_count
  );

  // Environment side (filter stage, VGA reader, SRAM controller).
  modport master (
    output pix_valid, pix_x, pix_y, pix_data, freeze,
    output rd_req, rd_addr,
    input  rd_data, rd_valid,
    input  sram_address, sram_read, sram_write, sram_writedata,
    output sram_readdata, sram_readdatavalid,
    input  fifo_level, drop_count
  );

endinterface

// File: rtl/frame_write_arbiter_fifo.sv
// Small synchronous FIFO of pending pixel writes. Head is read
// combinationally so the arbiter can issue it in the same cycle it pops.
module pixel_fifo
  import frame_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  pixel_entry_t           din,
  output pixel_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  pixel_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  // Guard against overflow/underflow; a push into a full FIFO is legal
  // only when the head leaves in the same cycle.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Queues camera pixels and writes them to SRAM in cycles the VGA reader
// leaves free. VGA reads always own the port; pixels arriving while the
// queue is full are dropped and counted.
module frame_write_arbiter
  import frame_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int H_MAX = H_MAX_DEFAULT,
  parameter int V_MAX = V_MAX_DEFAULT
) (
  input logic                  Clk,
  input logic                  Reset,
  frame_write_arbiter_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  arb_op_t          op;
  logic             pix_ok;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  pixel_entry_t     din;
  pixel_entry_t     head;
  logic [LVL_W-1:0] level;

  logic             sram_read_q;
  logic             sram_write_q;
  logic [19:0]      sram_address_q;
  logic [15:0]      sram_writedata_q;
  logic [15:0]      rd_data_q;
  logic             rd_valid_q;
  logic [15:0]      drop_count_q;

  // Port decision from the current queue state: read beats write, write only if queued.
  always_comb begin
    op = ARB_IDLE;
    if (bus.rd_req)  op = ARB_READ;
    else if (!empty) op = ARB_WRITE;
  end

  assign pop    = (op == ARB_WRITE);
  assign pix_ok = bus.pix_valid & ~bus.freeze & in_frame(bus.pix_x, bus.pix_y, H_MAX, V_MAX);
  assign push   = pix_ok & (~full | pop);
  assign drop   = pix_ok & full & ~pop;
  assign din    = '{addr: {bus.pix_y, bus.pix_x}, data: bus.pix_data};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Register the chosen command; address/data hold their value when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sram_read_q      <= 1'b0;
      sram_write_q     <= 1'b0;
      sram_address_q   <= '0;
      sram_writedata_q <= '0;
    end else begin
      sram_read_q  <= (op == ARB_READ);
      sram_write_q <= (op == ARB_WRITE);
      case (op)
        ARB_READ:  sram_address_q <= bus.rd_addr;
        ARB_WRITE: begin
          sram_address_q   <= head.addr;
          sram_writedata_q <= head.data;
        end
        default: ;
      endcase
    end
  end

  // Return read data to the VGA path one cycle after the controller, in order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= bus.sram_readdata;
      rd_valid_q <= bus.sram_readdatavalid;
    end
  end

  // Count pixels lost to a full queue, sticking at all-ones.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                              drop_count_q <= '0;
    else if (drop && drop_count_q != '1)    drop_count_q <= drop_count_q + 16'd1;
  end

  assign bus.sram_read      = sram_read_q;
  assign bus.sram_write     = sram_write_q;
  assign bus.sram_address   = sram_address_q;
  assign bus.sram_writedata = sram_writedata_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.fifo_level     = level;
  assign bus.drop_count     = drop_count_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_frame_write_arbiter;
  import frame_write_arbiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int H_MAX = 640;
  localparam int V_MAX = 480;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  frame_write_arbiter_if #(.DEPTH(DEPTH)) bus();

  frame_write_arbiter #(.DEPTH(DEPTH), .H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [35:0] exp_q[$];       // pending writes {addr, data}, oldest first
  int          m_drops;
  logic        m_read, m_write, m_rd_valid;
  logic [19:0] m_addr;
  logic [15:0] m_wdata, m_rd_data;

  task automatic model_clear();
    exp_q.delete();
    m_drops = 0; m_read = 0; m_write = 0; m_rd_valid = 0;
    m_addr = '0; m_wdata = '0; m_rd_data = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_data = '0;
    bus.freeze = 0; bus.rd_req = 0; bus.rd_addr = '0;
    bus.sram_readdata = '0; bus.sram_readdatavalid = 0;
  endtask

  task automatic drive_pixel(input logic v, input logic [9:0] x, input logic [9:0] y,
                             input logic [15:0] d);
    bus.pix_valid = v; bus.pix_x = x; bus.pix_y = y; bus.pix_data = d;
  endtask

  // Advance one clock; the model applies the port rules to the inputs held
  // this cycle, then outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic        n_read, n_write, fits;
    logic [19:0] n_addr;
    logic [15:0] n_wdata;
    logic [35:0] hd;
    fits = bus.pix_valid && !bus.freeze && (int'(bus.pix_x) < H_MAX) && (int'(bus.pix_y) < V_MAX);
    n_addr = m_addr; n_wdata = m_wdata; n_read = 0; n_write = 0;
    if (bus.rd_req) begin
      n_read = 1; n_addr = bus.rd_addr;
    end else if (exp_q.size() > 0) begin
      hd = exp_q.pop_front();
      n_write = 1; n_addr = hd[35:16]; n_wdata = hd[15:0];
    end
    if (fits) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({bus.pix_y, bus.pix_x, bus.pix_data});
      else if (m_drops < 65535) m_drops++;
    end
    m_rd_valid = bus.sram_readdatavalid;
    m_rd_data  = bus.sram_readdata;
    @(posedge Clk);
    #1;
    m_read = n_read; m_write = n_write; m_addr = n_addr; m_wdata = n_wdata;
  endtask

  function automatic logic [9:0] rx(); return 10'($urandom_range(0, H_MAX - 1)); endfunction
  function automatic logic [9:0] ry(); return 10'($urandom_range(0, V_MAX - 1)); endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    Reset = 1;
    #23;
    n_tests++;
    if ({bus.sram_read, bus.sram_write, bus.rd_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.sram_read, bus.sram_write, bus.rd_valid});
    end
    n_tests++;
    if ({bus.sram_address, bus.sram_writedata, bus.rd_data} !== 52'd0) begin
      n_fail++; $display("FAIL reset_buses: got %h expected 0", {bus.sram_address, bus.sram_writedata, bus.rd_data});
    end
    n_tests++;
    if (bus.fifo_level !== 5'd0 || bus.drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_level_drops: got %0d/%0d expected 0/0", bus.fifo_level, bus.drop_count);
    end
    @(negedge Clk); Reset = 0;
    @(posedge Clk); #1;
    model_clear();
  endtask

  task automatic test_single_write();
    drive_pixel(1, 10'd5, 10'd3, 16'hF800);
    tick();
    drive_idle();
    n_tests++;
    if (bus.sram_write !== 1'b0 || bus.fifo_level !== 5'd1) begin
      n_fail++; $display("FAIL single_t1: got write=%b level=%0d expected 0/1", bus.sram_write, bus.fifo_level);
    end
    tick();
    n_tests++;
    if (bus.sram_write !== 1'b1 || bus.sram_read !== 1'b0) begin
      n_fail++; $display("FAIL single_t2_strobe: got w=%b r=%b expected 1/0", bus.sram_write, bus.sram_read);
    end
    n_tests++;
    if (bus.sram_address !== 20'h00C05 || bus.sram_writedata !== 16'hF800) begin
      n_fail++; $display("FAIL single_t2_payload: got %h/%h expected 00c05/f800", bus.sram_address, bus.sram_writedata);
    end
    n_tests++;
    if (bus.fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL single_level: got %0d expected 0", bus.fifo_level);
    end
    tick();
    n_tests++;
    if (bus.sram_write !== 1'b0 || bus.sram_address !== 20'h00C05 || bus.sram_writedata !== 16'hF800) begin
      n_fail++; $display("FAIL single_idle_hold: got w=%b %h/%h expected 0 00c05/f800",
                         bus.sram_write, bus.sram_address, bus.sram_writedata);
    end
  endtask

  task automatic test_fill_under_read();
    logic [35:0] pushed[20];
    logic [9:0] x, y; logic [15:0] d;
    int bad;
    bad = 0;
    bus.rd_req = 1;
    for (int i = 0; i < 20; i++) begin
      x = rx(); y = ry(); d = 16'($urandom);
      pushed[i] = {y, x, d};
      bus.rd_addr = 20'($urandom);
      drive_pixel(1, x, y, d);
      tick();
      if (bus.sram_write !== 1'b0 || bus.sram_read !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fill_read_priority: got %0d bad cycles expected 0", bad);
    end
    n_tests++;
    if (bus.fifo_level !== 5'd16 || bus.drop_count !== 16'd4) begin
      n_fail++; $display("FAIL fill_level_drops: got %0d/%0d expected 16/4", bus.fifo_level, bus.drop_count);
    end
    drive_idle();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.sram_write !== 1'b1 || {bus.sram_address, bus.sram_writedata} !== pushed[i]) begin
        bad++;
        $display("FAIL fill_drain_order[%0d]: got w=%b %h expected 1 %h", i, bus.sram_write,
                 {bus.sram_address, bus.sram_writedata}, pushed[i]);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    tick();
    n_tests++;
    if (bus.sram_write !== 1'b0 || bus.fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL fill_idle_after: got w=%b level=%0d expected 0/0", bus.sram_write, bus.fifo_level);
    end
  endtask

  task automatic test_read_return();
    bus.rd_req = 1; bus.rd_addr = 20'h12345;
    tick();
    n_tests++;
    if (bus.sram_read !== 1'b1 || bus.sram_write !== 1'b0 || bus.sram_address !== 20'h12345) begin
      n_fail++; $display("FAIL read_cmd: got r=%b w=%b %h expected 1/0 12345", bus.sram_read, bus.sram_write, bus.sram_address);
    end
    bus.rd_req = 0; bus.sram_readdatavalid = 1; bus.sram_readdata = 16'hABCD;
    tick();
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hABCD || bus.sram_read !== 1'b0) begin
      n_fail++; $display("FAIL read_return: got v=%b %h r=%b expected 1 abcd 0", bus.rd_valid, bus.rd_data, bus.sram_read);
    end
    drive_idle();
    tick();
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_valid_drop: got %b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_out_of_range();
    bus.rd_req = 1;
    for (int i = 0; i < 16; i++) begin drive_pixel(1, rx(), ry(), 16'($urandom)); tick(); end
    drive_pixel(1, 10'd640, 10'd100, 16'h1111); tick();
    drive_pixel(1, 10'd10, 10'd480, 16'h2222); tick();
    drive_pixel(1, 10'd1, 10'd1, 16'h3333); bus.freeze = 1; tick();
    bus.freeze = 0;
    n_tests++;
    if (bus.drop_count !== 16'(m_drops) || m_drops != 4 || bus.fifo_level !== 5'd16) begin
      n_fail++; $display("FAIL range_no_drop: got drops=%0d level=%0d expected 4/16", bus.drop_count, bus.fifo_level);
    end
    drive_pixel(1, 10'd639, 10'd479, 16'h4444); tick();
    n_tests++;
    if (bus.drop_count !== 16'd5) begin
      n_fail++; $display("FAIL range_edge_drop: got %0d expected 5", bus.drop_count);
    end
    drive_idle();
    for (int i = 0; i < 18; i++) tick();
    drive_pixel(1, 10'd640, 10'd0, 16'h5555); tick();
    n_tests++;
    if (bus.fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL range_x_reject: got level %0d expected 0", bus.fifo_level);
    end
    drive_pixel(1, 10'd639, 10'd479, 16'h6666); tick();
    drive_idle();
    n_tests++;
    if (bus.fifo_level !== 5'd1) begin
      n_fail++; $display("FAIL range_edge_accept: got level %0d expected 1", bus.fifo_level);
    end
    tick();
    n_tests++;
    if (bus.sram_write !== 1'b1 || bus.sram_address !== {10'd479, 10'd639} || bus.sram_writedata !== 16'h6666) begin
      n_fail++; $display("FAIL range_edge_write: got w=%b %h/%h expected 1 %h/6666", bus.sram_write,
                         bus.sram_address, bus.sram_writedata, {10'd479, 10'd639});
    end
    tick();
  endtask

  task automatic test_full_stream();
    int drops0, bad;
    bus.rd_req = 1;
    for (int i = 0; i < 16; i++) begin drive_pixel(1, rx(), ry(), 16'($urandom)); tick(); end
    drops0 = m_drops;
    bus.rd_req = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive_pixel(1, rx(), ry(), 16'($urandom));
      tick();
      if (bus.fifo_level !== 5'd16 || bus.drop_count !== 16'(drops0)) bad++;
      if (bus.sram_write !== 1'b1 || bus.sram_address !== m_addr || bus.sram_writedata !== m_wdata) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL full_stream: got %0d bad cycles expected 0 (level=%0d drops=%0d)",
                         bad, bus.fifo_level, bus.drop_count);
    end
    drive_idle();
    for (int i = 0; i < 17; i++) tick();
    n_tests++;
    if (bus.fifo_level !== 5'd0 || bus.sram_write !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: got level=%0d w=%b expected 0/0", bus.fifo_level, bus.sram_write);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.rd_req   = ($urandom_range(0, 99) < 40);
      bus.rd_addr  = 20'($urandom);
      bus.freeze   = ($urandom_range(0, 9) == 0);
      drive_pixel($urandom_range(0, 9) < 7, 10'($urandom_range(0, 700)), 10'($urandom_range(0, 520)), 16'($urandom));
      bus.sram_readdatavalid = $urandom_range(0, 1);
      bus.sram_readdata      = 16'($urandom);
      tick();
      if (bus.sram_read !== m_read || bus.sram_write !== m_write || bus.sram_address !== m_addr ||
          bus.sram_writedata !== m_wdata || bus.rd_valid !== m_rd_valid || bus.rd_data !== m_rd_data ||
          bus.fifo_level !== 5'(exp_q.size()) || bus.drop_count !== 16'(m_drops)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: got r=%b w=%b %h/%h v=%b %h lvl=%0d drp=%0d expected r=%b w=%b %h/%h v=%b %h lvl=%0d drp=%0d",
                   i, bus.sram_read, bus.sram_write, bus.sram_address, bus.sram_writedata, bus.rd_valid,
                   bus.rd_data, bus.fifo_level, bus.drop_count, m_read, m_write, m_addr, m_wdata,
                   m_rd_valid, m_rd_data, exp_q.size(), m_drops);
      end
      n_tests++;
      if (bad > 0 && i == 399) n_fail++;
    end
    drive_idle();
    for (int i = 0; i < 18; i++) tick();
  endtask

  task automatic test_async_reset();
    int bad;
    bus.rd_req = 1;
    for (int i = 0; i < 8; i++) begin drive_pixel(1, rx(), ry(), 16'($urandom)); tick(); end
    bus.rd_req = 0;
    drive_pixel(1, rx(), ry(), 16'($urandom));
    tick();
    n_tests++;
    if (bus.fifo_level !== 5'd8 || bus.sram_write !== 1'b1) begin
      n_fail++; $display("FAIL areset_setup: got level=%0d w=%b expected 8/1", bus.fifo_level, bus.sram_write);
    end
    #3 Reset = 1;
    #1;
    n_tests++;
    if ({bus.sram_read, bus.sram_write, bus.rd_valid, bus.sram_address, bus.sram_writedata,
         bus.rd_data, bus.fifo_level, bus.drop_count} !== '0) begin
      n_fail++; $display("FAIL areset_immediate: got w=%b lvl=%0d drp=%0d addr=%h expected all 0",
                         bus.sram_write, bus.fifo_level, bus.drop_count, bus.sram_address);
    end
    drive_idle();
    @(posedge Clk); #2 Reset = 0;
    @(posedge Clk); #1;
    model_clear();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.sram_write !== 1'b0 || bus.fifo_level !== 5'd0 || bus.drop_count !== 16'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL areset_quiet: got %0d bad cycles expected 0", bad);
    end
    drive_pixel(1, 10'd7, 10'd2, 16'h07E0); tick();
    drive_idle(); tick();
    n_tests++;
    if (bus.sram_write !== 1'b1 || bus.sram_address !== 20'h00807 || bus.sram_writedata !== 16'h07E0) begin
      n_fail++; $display("FAIL areset_new_push: got w=%b %h/%h expected 1 00807/07e0",
                         bus.sram_write, bus.sram_address, bus.sram_writedata);
    end
    tick();
  endtask

  task automatic test_drop_saturate();
    bus.rd_req = 1;
    drive_pixel(1, 10'd100, 10'd100, 16'hBEEF);
    for (int i = 0; i < 65535 + 16 + 3; i++) tick();
    n_tests++;
    if (bus.drop_count !== 16'hFFFF || m_drops != 65535) begin
      n_fail++; $display("FAIL drop_saturate: got %h expected ffff", bus.drop_count);
    end
    drive_idle();
    for (int i = 0; i < 18; i++) tick();
    n_tests++;
    if (bus.drop_count !== 16'hFFFF || bus.fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL drop_hold: got %h lvl=%0d expected ffff/0", bus.drop_count, bus.fifo_level);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_single_write();
    test_fill_under_read();
    test_read_return();
    test_out_of_range();
    test_full_stream();
    test_random();
    test_async_reset();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the whole run is a fixed number of cycles, far below this bound.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
